// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// master = loader side, slave = host/memory side.
interface instr_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream, writes it
// word by word into instruction memory, then releases the core from reset.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic           clk,
    input  logic           reset,
    instr_loader_if.master bus
);
    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t           r_state;
    logic [15:0]      r_len;
    logic [1:0]       r_byte_cnt;
    logic [IDX_W-1:0] r_word_idx;
    logic [7:0]       r_csum;
    logic [23:0]      r_asm;
    logic             r_rx_ready;
    logic             r_imem_we;
    logic [31:0]      r_imem_addr;
    logic [31:0]      r_imem_wdata;
    logic             r_core_reset;
    logic             r_done;
    logic             r_error;

    logic             w_accept;
    logic [15:0]      w_len_full;
    logic             w_len_bad;
    logic [31:0]      w_word_addr;
    logic             w_last_word;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_len_full  = {bus.rx_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > 32'(MAX_WORDS));
    assign w_word_addr = BASE_ADDR + (32'(r_word_idx) << 2);
    // The word index never reaches N, so comparing idx+1 against N flags the final word.
    assign w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_len));

    // Loader FSM with datapath and registered status/write outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_LEN0;
            r_len        <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_word_idx   <= '0;
            r_csum       <= 8'd0;
            r_asm        <= 24'd0;
            r_rx_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 32'd0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_LEN0: begin
                        r_len[7:0] <= bus.rx_data;
                        r_state    <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        r_len[15:8] <= bus.rx_data;
                        if (w_len_bad) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_csum     <= r_csum ^ bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_asm[7:0]   <= bus.rx_data;
                            2'd1: r_asm[15:8]  <= bus.rx_data;
                            2'd2: r_asm[23:16] <= bus.rx_data;
                            default: begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= w_word_addr;
                                r_imem_wdata <= {bus.rx_data, r_asm};
                                if (w_last_word) begin
                                    r_state <= ST_CHECK;
                                end else begin
                                    r_word_idx <= r_word_idx + 1'b1;
                                end
                            end
                        endcase
                    end
                    ST_CHECK: begin
                        r_rx_ready <= 1'b0;
                        if (bus.rx_data == r_csum) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.core_reset = r_core_reset;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: stream-position model plus a
// per-cycle compare process and literal expectations per scenario.
module tb_instr_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    instr_loader_if bus();

    instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Model: position in the stream, length, checksum, status 0=loading 1=run 2=err
    int          m_pos;
    int          m_len;
    int          m_status;
    logic [7:0]  m_csum;
    logic [31:0] m_word;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_status;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk1(input string name, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare and write logging.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("rx_ready",   bus.rx_ready,   exp_status == 0);
            chk1("done",       bus.done,       exp_status == 1);
            chk1("error",      bus.error,      exp_status == 2);
            chk1("core_reset", bus.core_reset, exp_status != 1);
            chk1("imem_we",    bus.imem_we,    exp_we);
            if (exp_we) begin
                chk32("imem_addr",  bus.imem_addr,  exp_addr);
                chk32("imem_wdata", bus.imem_wdata, exp_data);
            end
        end
        if (bus.imem_we === 1'b1) begin
            log_addr.push_back(bus.imem_addr);
            log_data.push_back(bus.imem_wdata);
        end
    end

    task automatic model_reset();
        m_pos      = 0;
        m_len      = 0;
        m_status   = 0;
        m_csum     = 8'h00;
        m_word     = 32'h0;
        exp_we     = 1'b0;
        exp_status = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        logic        nx_we;
        logic [31:0] nx_addr;
        logic [31:0] nx_data;
        int          o;
        nx_we   = 1'b0;
        nx_addr = 32'h0;
        nx_data = 32'h0;
        bus.rx_valid = v;
        bus.rx_data  = d;
        if (v && m_status == 0) begin
            if (m_pos == 0) begin
                m_len = int'(d);
            end else if (m_pos == 1) begin
                m_len = m_len + 256 * int'(d);
                if (m_len == 0 || m_len > MAXW) m_status = 2;
            end else if (m_pos < 2 + 4 * m_len) begin
                o = m_pos - 2;
                m_csum = m_csum ^ d;
                m_word[8*(o%4) +: 8] = d;
                if (o % 4 == 3) begin
                    nx_we   = 1'b1;
                    nx_addr = BASE + 32'(4 * (o / 4));
                    nx_data = m_word;
                    m_word  = 32'h0;
                end
            end else begin
                m_status = (d == m_csum) ? 1 : 2;
            end
            m_pos++;
        end
        @(posedge clk);
        #1;
        exp_we     = nx_we;
        exp_addr   = nx_addr;
        exp_data   = nx_data;
        exp_status = m_status;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'(($urandom)));
    endtask

    task automatic send(input logic [7:0] q[$], input int max_gap);
        foreach (q[i]) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            step(1'b1, q[i]);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        #1;
        chk1("rst_rx_ready",   bus.rx_ready,   1'b1);
        chk1("rst_core_reset", bus.core_reset, 1'b1);
        chk1("rst_imem_we",    bus.imem_we,    1'b0);
        chk1("rst_done",       bus.done,       1'b0);
        chk1("rst_error",      bus.error,      1'b0);
        chk32("rst_imem_addr",  bus.imem_addr,  BASE);
        chk32("rst_imem_wdata", bus.imem_wdata, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    logic [7:0] s_ok[$];
    logic [7:0] s_bad[$];
    logic [7:0] s_tmp[$];

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        s_ok  = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        s_bad = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        #2;
        do_reset();
        chk_en = 1'b1;

        // Single-word program with matching checksum.
        clear_log();
        send(s_ok, 0);
        idle(3);
        chk32("ok_nwrites", 32'(log_data.size()), 32'd1);
        if (log_data.size() == 1) begin
            chk32("ok_addr", log_addr[0], 32'h0000_0000);
            chk32("ok_data", log_data[0], 32'h00A0_0513);
        end
        chk1("ok_done",   bus.done,       1'b1);
        chk1("ok_corerst", bus.core_reset, 1'b0);
        chk1("ok_ready",  bus.rx_ready,   1'b0);

        // Two words, wrong checksum (correct would be 0x88).
        do_reset();
        clear_log();
        send(s_bad, 0);
        idle(3);
        chk32("bad_nwrites", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk32("bad_addr0", log_addr[0], 32'h0000_0000);
            chk32("bad_data0", log_data[0], 32'h4433_2211);
            chk32("bad_addr1", log_addr[1], 32'h0000_0004);
            chk32("bad_data1", log_data[1], 32'h8877_6655);
        end
        chk1("bad_error",   bus.error,      1'b1);
        chk1("bad_corerst", bus.core_reset, 1'b1);

        // Zero length.
        do_reset();
        clear_log();
        s_tmp = '{8'h00, 8'h00};
        send(s_tmp, 0);
        chk1("len0_error", bus.error, 1'b1);
        idle(2);
        chk32("len0_nwrites", 32'(log_data.size()), 32'd0);

        // Length 257 exceeds MAX_WORDS.
        do_reset();
        clear_log();
        s_tmp = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send(s_tmp, 0);
        chk1("len257_error", bus.error, 1'b1);
        idle(2);
        chk32("len257_nwrites", 32'(log_data.size()), 32'd0);

        // Reset in the middle of a word, then the full stream.
        do_reset();
        clear_log();
        s_tmp = '{8'h01, 8'h00, 8'h13, 8'h05};
        send(s_tmp, 0);
        do_reset();
        send(s_ok, 0);
        idle(3);
        chk32("mid_nwrites", 32'(log_data.size()), 32'd1);
        if (log_data.size() == 1) chk32("mid_data", log_data[0], 32'h00A0_0513);
        chk1("mid_done", bus.done, 1'b1);

        // Random gaps, then extra bytes after done.
        do_reset();
        clear_log();
        send(s_ok, 3);
        send(s_ok, 2);
        idle(3);
        chk32("gap_nwrites", 32'(log_data.size()), 32'd1);
        if (log_data.size() == 1) chk32("gap_data", log_data[0], 32'h00A0_0513);
        chk1("gap_done", bus.done, 1'b1);

        // Maximum length: 256 words of bytes 0..1023, checksum of that is 0.
        do_reset();
        clear_log();
        s_tmp = '{8'h00, 8'h01};
        for (int i = 0; i < 1024; i++) s_tmp.push_back(8'(i));
        s_tmp.push_back(8'h00);
        send(s_tmp, 0);
        idle(3);
        chk32("max_nwrites", 32'(log_data.size()), 32'd256);
        if (log_data.size() == 256) begin
            chk32("max_last_addr", log_addr[255], 32'h0000_03FC);
            chk32("max_last_data", log_data[255], 32'hFFFE_FDFC);
        end
        chk1("max_done", bus.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted program length in 32-bit words.
REQ-003 Port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port rx_valid, input, 1, a byte is offered on rx_data.
REQ-006 Port rx_data, input, 8, the offered byte.
REQ-007 Port rx_ready, output, 1, the loader can accept a byte; a byte transfers on a cycle with rx_valid=1 and rx_ready=1.
REQ-008 Port imem_we, output, 1, instruction-memory write strobe, one cycle per word.
REQ-009 Port imem_addr, output, 32, byte address for the write.
REQ-010 Port imem_wdata, output, 32, instruction word for the write.
REQ-011 Port core_reset, output, 1, holds the processor core in reset while high.
REQ-012 Port done, output, 1, the program loaded and the checksum matched.
REQ-013 Port error, output, 1, the load was rejected.

Function
REQ-014 The byte stream format SHALL be: length low byte, length high byte (N, 16-bit), then 4N payload bytes, then 1 checksum byte.
REQ-015 Payload words SHALL be little-endian: the first byte of each group of four is bits [7:0].
REQ-016 FSM states SHALL be LEN0, LEN1, DATA, CHECK, RUN and ERR.
REQ-017 LEN0: an accepted byte is stored as N[7:0], then the FSM goes to LEN1.
REQ-018 LEN1: an accepted byte is stored as N[15:8].
REQ-019 LEN1 exit: if N=0 or N>MAX_WORDS, go to ERR; otherwise go to DATA.
REQ-020 DATA: each accepted byte is XORed into an 8-bit checksum accumulator, which is cleared on entry to LEN0.
REQ-021 DATA: a 2-bit byte counter advances per accepted byte and wraps 3->0.
REQ-022 On acceptance of the 4th byte of word k (k from 0), the cycle immediately after SHALL drive imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4k and imem_wdata=the assembled word.
REQ-023 Write latency (REQ-022) SHALL be one cycle; the next byte may be accepted in the same cycle as the write without loss.
REQ-024 After word N-1 is accepted, the FSM SHALL go to CHECK.
REQ-025 CHECK: on the accepted byte, go to RUN if it equals the accumulator, otherwise go to ERR.
REQ-026 rx_ready SHALL be 1 in LEN0, LEN1, DATA and CHECK, and 0 in RUN and ERR.
REQ-027 Bytes offered while rx_ready=0 SHALL be ignored and SHALL cause no state change.
REQ-028 Cycles with rx_valid=0 SHALL leave all state unchanged; gaps of any length between bytes are legal.
REQ-029 core_reset SHALL be 1 in every state except RUN, and 0 in RUN.
REQ-030 done SHALL be 1 only in RUN.
REQ-031 error SHALL be 1 only in ERR.
REQ-032 RUN and ERR SHALL be terminal; only reset leaves them.
REQ-033 imem_we SHALL be 0 whenever no write is due and always 0 in LEN0, LEN1, RUN and ERR.
REQ-034 Word address arithmetic SHALL be 32-bit modulo 2^32.
REQ-035 The word index SHALL be wide enough for MAX_WORDS.

Reset
REQ-036 Asserting reset, including mid-DATA, SHALL immediately force: state LEN0, core_reset=1, imem_we=0, done=0, error=0, rx_ready=1.
REQ-037 Asserting reset SHALL also clear the byte counter, word index and checksum to 0, with imem_addr=BASE_ADDR and imem_wdata=0.
REQ-038 A partially assembled word SHALL be discarded by reset and never written.

Verification
REQ-039 Bytes 01 00 13 05 A0 00 B6 -> one write of addr 0x0 with data 0x00A00513; done=1; core_reset=0; rx_ready=0.
REQ-040 Bytes 02 00, then 8 payload bytes, then a wrong checksum -> exactly two writes to 0x0 and 0x4, then error=1 with core_reset held at 1.
REQ-041 Length 00 00 -> ERR right after the second byte; no imem_we pulse.
REQ-042 Length 01 01 (257) with MAX_WORDS=256 -> ERR with no writes.
REQ-043 Reset pulsed after 2 payload bytes, then the full stream of REQ-039 -> a single write of 0x00A00513 and done=1.
REQ-044 The stream of REQ-039 with random rx_valid gaps, plus extra bytes offered after done -> identical writes; extra bytes are ignored.
